// File: rtl/seg_scroll_sequencer_if.sv
// Pad-side bundle of the message sequencer: button/mode controls in, segment drive and status out.
// The master side drives the controls; the sequencer attaches as the slave.
interface seg_scroll_sequencer_if;
    logic       step_btn;
    logic       auto_en;
    logic       halt;
    logic [6:0] seg_out;
    logic [3:0] letter_idx;
    logic       blank;
    logic       wrap;

    modport master (
        output step_btn, auto_en, halt,
        input  seg_out, letter_idx, blank, wrap
    );

    modport slave (
        input  step_btn, auto_en, halt,
        output seg_out, letter_idx, blank, wrap
    );
endinterface

// File: rtl/seg_scroll_sequencer.sv
// Steps the "SEnOLGULGONUL" message one glyph at a time, by push-button or dwell timer, with a
// blank gap between glyphs. Define SEQ_DEBOUNCE_EN to insert the button debounce filter.
module seg_scroll_sequencer #(
    parameter int unsigned NUM_LETTERS     = 13,
    parameter int unsigned SHOW_CYCLES     = 8,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    seg_scroll_sequencer_if.slave bus_io
);

    localparam int unsigned DwellW  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]  LastIdx = 4'(NUM_LETTERS - 1);

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    // Button path: synchronizer, optional filter, rising-edge detect.
    logic sync1_q, sync2_q;
    logic level, level_prev_q;
    logic step_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= bus_io.step_btn;
            sync2_q      <= sync1_q;
            level_prev_q <= level;
        end
    end

`ifdef SEQ_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           db_level_q, db_level_d;

    // Counts consecutive samples that disagree with the accepted level; any agreement restarts it.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    assign level = db_level_q;
`else
    logic unused_db;
    assign unused_db = (DEBOUNCE_CYCLES != 0);
    assign level     = sync2_q;
`endif

    assign step_pulse = level & ~level_prev_q;

    function automatic logic [6:0] glyph(input logic [3:0] i);
        case (i)
            4'd0:               return 7'b1011011;
            4'd1:               return 7'b1001111;
            4'd2, 4'd10:        return 7'b0010101;
            4'd3, 4'd9:         return 7'b1111110;
            4'd4, 4'd7, 4'd12:  return 7'b0001110;
            4'd5, 4'd8:         return 7'b1011111;
            4'd6, 4'd11:        return 7'b0111110;
            default:            return 7'b0000000;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d, next_idx;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [6:0]          seg_q, seg_d;
    logic                blank_q, blank_d;
    logic                wrap_q, wrap_d;
    logic                advance;

    assign next_idx = (idx_q == LastIdx) ? 4'd0 : idx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        wrap_d  = 1'b0;
        advance = 1'b0;

        if (bus_io.halt) begin
            state_d = StIdle;
            idx_d   = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (step_pulse || bus_io.auto_en) begin
                        state_d = StShow;
                        idx_d   = 4'd0;
                        dwell_d = '0;
                    end
                end
                StShow: begin
                    if (bus_io.auto_en) begin
                        if (dwell_q == DwellW'(SHOW_CYCLES - 1)) begin
                            advance = 1'b1;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end else begin
                        advance = step_pulse;
                    end
                    if (advance) begin
                        if (GAP_CYCLES == 0) begin
                            idx_d   = next_idx;
                            dwell_d = '0;
                            wrap_d  = (next_idx == 4'd0);
                        end else begin
                            state_d = StGap;
                            gap_d   = '0;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                        state_d = StShow;
                        idx_d   = next_idx;
                        dwell_d = '0;
                        wrap_d  = (next_idx == 4'd0);
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered, so they are derived from the state being entered.
        blank_d = (state_d != StShow);
        seg_d   = blank_d ? 7'b0000000 : glyph(idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dwell_q <= '0;
            gap_q   <= '0;
            seg_q   <= '0;
            blank_q <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            seg_q   <= seg_d;
            blank_q <= blank_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus_io.seg_out    = seg_q;
    assign bus_io.letter_idx = idx_q;
    assign bus_io.blank      = blank_q;
    assign bus_io.wrap       = wrap_q;

endmodule

// File: tb/tb_seg_scroll_sequencer.sv
// Bench for seg_scroll_sequencer: per-cycle comparison against a behavioural message model plus
// literal expectations at key points. Follows SEQ_DEBOUNCE_EN the same way the design does.
`timescale 1ns/1ps
module tb_seg_scroll_sequencer;
    localparam int N = 13;
    localparam int S = 8;
    localparam int G = 2;
    localparam int D = 4;
`ifdef SEQ_DEBOUNCE_EN
    localparam bit FiltOn = 1'b1;
`else
    localparam bit FiltOn = 1'b0;
`endif
    // Raw button sample -> FSM edge that acts on it; press-to-output latency in edges.
    localparam int PulseDly = FiltOn ? 3 : 2;
    localparam int Lat      = FiltOn ? 2 + D : 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scroll_sequencer_if bus ();

    seg_scroll_sequencer #(
        .NUM_LETTERS     (N),
        .SHOW_CYCLES     (S),
        .GAP_CYCLES      (G),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [N] = '{7'b1011011, 7'b1001111, 7'b0010101, 7'b1111110, 7'b0001110,
                              7'b1011111, 7'b0111110, 7'b0001110, 7'b1011111, 7'b1111110,
                              7'b0010101, 7'b0111110, 7'b0001110};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: dut=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_active, m_wrap;
    int       m_idx, m_dwell, m_gap_left;
    bit       run_v, acc, prev_s;
    int       run_len;
    bit [2:0] rise_hist;

    always @(posedge clk or posedge rst) begin : model_step
        bit s, rise, pulse, adv;
        int rl, nidx;
        if (rst) begin
            m_active   <= 1'b0;
            m_wrap     <= 1'b0;
            m_idx      <= 0;
            m_dwell    <= 0;
            m_gap_left <= 0;
            run_v      <= 1'b0;
            run_len    <= D + 1;
            acc        <= 1'b0;
            prev_s     <= 1'b0;
            rise_hist  <= '0;
        end else begin
            s     = bus.step_btn;
            pulse = rise_hist[PulseDly-1];
            rl    = (s != run_v) ? 1 : ((run_len > D) ? run_len : run_len + 1);
            if (FiltOn) begin
                rise = (rl == D) && s && !acc;
                if (rl == D) acc <= s;
            end else begin
                rise = s && !prev_s;
            end
            run_v     <= s;
            run_len   <= rl;
            prev_s    <= s;
            rise_hist <= {rise_hist[1:0], rise};

            nidx   = (m_idx == N - 1) ? 0 : m_idx + 1;
            adv    = 1'b0;
            m_wrap <= 1'b0;
            if (bus.halt) begin
                m_active   <= 1'b0;
                m_idx      <= 0;
                m_gap_left <= 0;
            end else if (!m_active) begin
                if (pulse || bus.auto_en) begin
                    m_active <= 1'b1;
                    m_idx    <= 0;
                    m_dwell  <= 0;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left <= m_gap_left - 1;
                if (m_gap_left == 1) begin
                    m_idx   <= nidx;
                    m_dwell <= 0;
                    m_wrap  <= (nidx == 0);
                end
            end else begin
                if (bus.auto_en) begin
                    if (m_dwell == S - 1) adv = 1'b1;
                    else m_dwell <= m_dwell + 1;
                end else begin
                    adv = pulse;
                end
                if (adv) m_gap_left <= G;
            end
        end
    end

    logic       exp_blank;
    logic [6:0] exp_seg;
    assign exp_blank = !m_active || (m_gap_left != 0);
    assign exp_seg   = exp_blank ? 7'b0 : glyph[m_idx];

    always @(negedge clk) begin
        if (!rst) begin
            chk("seg_out", bus.seg_out, exp_seg);
            chk("blank", bus.blank, exp_blank);
            chk("letter_idx", bus.letter_idx, m_idx);
            chk("wrap", bus.wrap, m_wrap);
        end
    end

    // ---------------- stimulus ----------------
    int wrap_seen;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.wrap) wrap_seen++;
        end
    endtask

    task automatic press(input int hold);
        bus.step_btn = 1'b1;
        tick(hold);
        bus.step_btn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    logic [6:0] man_exp [14] = '{7'b1011011, 7'b1001111, 7'b0010101, 7'b1111110, 7'b0001110,
                                 7'b1011111, 7'b0111110, 7'b0001110, 7'b1011111, 7'b1111110,
                                 7'b0010101, 7'b0111110, 7'b0001110, 7'b1011011};

    initial begin
        int cnt, bcnt, first_wrap;
        bus.step_btn = 1'b0;
        bus.auto_en  = 1'b0;
        bus.halt     = 1'b0;
        tick(3);
        rst = 1'b0;

        // Idle with no stimulus
        tick(30);
        chk("idle_seg", bus.seg_out, 0);
        chk("idle_blank", bus.blank, 1);
        chk("idle_idx", bus.letter_idx, 0);
        chk("idle_wrap", bus.wrap, 0);

        // Manual: 14 presses, 20 clocks apart
        wrap_seen = 0;
        for (int p = 0; p < 14; p++) begin
            press(8);
            tick(12);
            chk($sformatf("man_seg%0d", p), bus.seg_out, man_exp[p]);
            chk($sformatf("man_idx%0d", p), bus.letter_idx, p % N);
        end
        chk("man_wraps", wrap_seen, 1);

        // Halt during the gap after idx 5
        do_reset();
        for (int p = 0; p < 6; p++) begin
            press(8);
            tick(12);
        end
        chk("pre_halt_idx", bus.letter_idx, 5);
        bus.step_btn = 1'b1;
        cnt = 0;
        while (!(bus.blank && bus.letter_idx == 5) && cnt < 20) begin
            tick(1);
            cnt++;
        end
        chk("gap5_reached", int'(cnt < 20), 1);
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        chk("halt_idx", bus.letter_idx, 0);
        chk("halt_blank", bus.blank, 1);
        chk("halt_seg", bus.seg_out, 0);
        tick(4);
        bus.step_btn = 1'b0;
        tick(10);
        chk("halt_stays_idle", bus.blank, 1);

        // Press while halt held: dropped, not queued
        bus.halt = 1'b1;
        press(8);
        tick(6);
        bus.halt = 1'b0;
        tick(5);
        chk("halt_drop_step", bus.blank, 1);

        // Halt beats auto_en; release starts SHOW(0) without wrap
        bus.halt    = 1'b1;
        bus.auto_en = 1'b1;
        tick(5);
        chk("halt_auto_idle", bus.blank, 1);
        bus.halt = 1'b0;
        tick(1);
        chk("auto_start_seg", bus.seg_out, 7'b1011011);
        chk("auto_start_wrap", bus.wrap, 0);
        bus.auto_en = 1'b0;
        tick(4);

        // Second rising edge lands in the gap and must be dropped
        bus.step_btn = 1'b1; tick(1);
        bus.step_btn = 1'b0; tick(1);
        bus.step_btn = 1'b1; tick(1);
        bus.step_btn = 1'b0; tick(15);
        chk("gap_press_idx", bus.letter_idx, FiltOn ? 0 : 1);
        chk("gap_press_blank", bus.blank, 0);

        // Short 3-cycle pulse: only a filtered build rejects it
        do_reset();
        press(3);
        tick(15);
        chk("glitch_blank", bus.blank, FiltOn ? 1 : 0);

        // Latency of a clean 8-cycle press from idle
        do_reset();
        tick(3);
        bus.step_btn = 1'b1;
        cnt = 0;
        while (bus.blank && cnt < 30) begin
            tick(1);
            cnt++;
        end
        chk("press_latency", cnt, Lat + 1);
        tick(8 - cnt);
        bus.step_btn = 1'b0;
        tick(20);
        chk("once_idx", bus.letter_idx, 0);
        chk("once_seg", bus.seg_out, 7'b1011011);

        // Auto mode from reset release
        rst = 1'b1;
        bus.auto_en = 1'b1;
        tick(2);
        rst = 1'b0;
        wrap_seen  = 0;
        bcnt       = 0;
        first_wrap = 0;
        for (int c = 1; c <= 300; c++) begin
            tick(1);
            if (c == 1) chk("auto_first_seg", bus.seg_out, 7'b1011011);
            if (c == 45) begin
                chk("auto_c45_seg", bus.seg_out, 7'b0001110);
                chk("auto_c45_idx", bus.letter_idx, 4);
            end
            if (c <= 130 && bus.blank) bcnt++;
            if (bus.wrap && first_wrap == 0) first_wrap = c;
        end
        chk("auto_blank_cnt", bcnt, 26);
        chk("auto_first_wrap", first_wrap, 131);
        chk("auto_wraps", wrap_seen, 2);

        // auto_en dropped mid-SHOW then resumed
        bus.auto_en = 1'b0;
        tick(5);
        bus.auto_en = 1'b1;
        tick(40);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("async_rst_blank", bus.blank, 1);
        chk("async_rst_seg", bus.seg_out, 0);
        chk("async_rst_idx", bus.letter_idx, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_auto_seg", bus.seg_out, 7'b1011011);
        bus.auto_en = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
